// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and state encoding for the program loader
package prog_loader_pkg;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
    localparam int HDR_W          = 16;
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HDR  = 3'd1;
    localparam state_t ST_DATA = 3'd2;
    localparam state_t ST_CSUM = 3'd3;
    localparam state_t ST_RUN  = 3'd4;
    localparam state_t ST_ERR  = 3'd5;
endpackage

// File: rtl/loader_word_asm.sv
// loader_word_asm: collects accepted bytes little-endian into a 32-bit word
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           drop any partial word and restart the byte count
//   i_accept        a byte is taken this edge
//   i_byte          incoming byte
//   o_cnt           bytes of the current word taken so far
//   o_word          assembly register (first byte ends up in bits 7:0)
//   o_done          high for one cycle after the 4th byte of a word is taken
module loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [BCNT_W-1:0] o_cnt,
    output logic [WORD_W-1:0] o_word,
    output logic              o_done
);
    logic [BCNT_W-1:0] r_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_done;

    // Shifting right places the first byte of four at bits 7:0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_done <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= i_accept && (r_cnt == BCNT_W'(BYTES_PER_WORD - 1));
            if (i_accept) begin
                r_cnt  <= r_cnt + 1'b1;
                r_word <= {i_byte, r_word[WORD_W-1:BYTE_W]};
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_word = r_word;
    assign o_done = r_done;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed byte stream and writes it into instruction memory
//   clk_i, rst_i                     clock, async active-low reset
//   load_req_i                       start a new load (honoured in IDLE/RUN/ERR)
//   in_valid_i, in_data_i, in_ready_o  byte stream handshake
//   imem_we_o, imem_addr_o, imem_data_o  instruction-memory write port
//   start_o, busy_o, err_o, words_o  CPU start, load active, error, words written
//   Build option LOADER_CHECKSUM_EN adds an XOR checksum trailer check.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic              in_valid_i,
    input  logic [BYTE_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              imem_we_o,
    output logic [AW-1:0]     imem_addr_o,
    output logic [WORD_W-1:0] imem_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic              err_o,
    output logic [HDR_W-1:0]  words_o
);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CSUM;
    logic [WORD_W-1:0] r_acc;
`else
    localparam state_t ST_AFTER_DATA = ST_RUN;
`endif

    state_t            r_state;
    logic [HDR_W-1:0]  r_n;
    logic [HDR_W-1:0]  r_words;
    logic [AW-1:0]     r_addr;
    logic [BCNT_W-1:0] w_cnt;
    logic [WORD_W-1:0] w_word;
    logic              w_done;
    logic              w_acc;
    logic              w_load;
    logic              w_hdr_done;
    logic [HDR_W-1:0]  w_hdr_n;
    logic              w_hdr_bad;
    logic              w_fin;
    logic              w_last;
    logic              w_we;

    assign w_acc      = in_valid_i && in_ready_o;
    assign w_load     = load_req_i && (r_state == ST_IDLE || r_state == ST_RUN || r_state == ST_ERR);
    // The first header byte has been shifted to the top of the assembly register.
    assign w_hdr_n    = {in_data_i, w_word[WORD_W-1:WORD_W-BYTE_W]};
    assign w_hdr_done = (r_state == ST_HDR) && w_acc && (w_cnt == BCNT_W'(1));
    assign w_hdr_bad  = (w_hdr_n == '0) || ({16'b0, w_hdr_n} > 32'(MEM_WORDS));
    assign w_fin      = (r_state == ST_DATA) && w_acc && (w_cnt == BCNT_W'(BYTES_PER_WORD - 1));
    // All N words counted: the final write pulse is pending, so stop taking bytes.
    assign w_last     = (r_state == ST_DATA) && (r_words == r_n);
    assign w_we       = w_done && (r_state == ST_DATA);

    loader_word_asm u_asm (
        .i_clk    (clk_i),
        .i_rst_n  (rst_i),
        .i_clr    (w_load || w_hdr_done),
        .i_accept (w_acc),
        .i_byte   (in_data_i),
        .o_cnt    (w_cnt),
        .o_word   (w_word),
        .o_done   (w_done)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_words <= '0;
            r_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_acc   <= '0;
`endif
        end else if (w_load) begin
            r_state <= ST_HDR;
            r_n     <= '0;
            r_words <= '0;
            r_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_acc   <= '0;
`endif
        end else begin
            if (w_hdr_done) begin
                r_n     <= w_hdr_n;
                r_state <= w_hdr_bad ? ST_ERR : ST_DATA;
            end
            // Address holds the index of the word being written while words_o already counts it.
            if (w_fin) begin
                r_words <= r_words + 1'b1;
                r_addr  <= r_words[AW-1:0];
            end
            if (w_we && w_last)
                r_state <= ST_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            if (w_we)
                r_acc <= r_acc ^ w_word;
            if (r_state == ST_CSUM && w_done)
                r_state <= (w_word == r_acc) ? ST_RUN : ST_ERR;
`endif
        end
    end

    assign in_ready_o  = (r_state == ST_HDR || r_state == ST_CSUM || r_state == ST_DATA) && !w_last;
    assign busy_o      = r_state == ST_HDR || r_state == ST_DATA || r_state == ST_CSUM;
    assign imem_we_o   = w_we;
    assign imem_addr_o = r_addr;
    assign imem_data_o = w_word;
    assign start_o     = r_state == ST_RUN;
    assign err_o       = r_state == ST_ERR;
    assign words_o     = r_words;
endmodule
